// File: rtl/tas_serial_tx.sv
// tas_serial_tx: serialises a header byte plus four temperature bytes,
// LSB first, with a data_ena qualifier, fixed gaps between bytes and a
// fixed idle time after each packet.
module tas_serial_tx #(
  parameter int GAP_CYCLES = 2,  // data_ena-low cycles between bytes (1..15)
  parameter int PKT_GAP    = 4   // idle cycles after the last byte (1..15)
) (
  input  logic        clk_50,
  input  logic        reset,
  input  logic        tx_valid,
  input  logic [31:0] tx_temp,
  input  logic        tx_hdr_sel,
  output logic        tx_ready,
  output logic        serial_data,
  output logic        data_ena,
  output logic        subst,
  output logic [15:0] pkt_cnt
);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, PKT_WAIT} state_t;

  localparam logic [7:0] HDR_A    = 8'hA5;
  localparam logic [7:0] HDR_C    = 8'hC3;
  localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);
  localparam logic [3:0] WAIT_LAST = 4'(PKT_GAP - 1);

  state_t      state_reg, state_next;
  logic [39:0] pkt_reg;       // {byte3, byte2, byte1, byte0, header}
  logic [2:0]  bit_cnt_reg;
  logic [2:0]  byte_idx_reg;  // 0 = header, 4 = byte3
  logic [3:0]  gap_cnt_reg;   // shared by GAP and PKT_WAIT
  logic        subst_reg;
  logic [15:0] pkt_cnt_reg;

  logic        accept;
  logic [5:0]  bit_pos;
  logic [7:0]  hdr_byte;
  logic [7:0]  clean_byte [4];
  logic [3:0]  byte_hit;

  // Header values must never appear inside the payload, so nudge them down by one.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_clean
      logic [7:0] raw;
      assign raw            = tx_temp[gi*8 +: 8];
      assign byte_hit[gi]   = (raw == HDR_A) || (raw == HDR_C);
      assign clean_byte[gi] = (raw == HDR_A) ? 8'hA4 :
                              (raw == HDR_C) ? 8'hC2 : raw;
    end
  endgenerate

  assign accept   = (state_reg == IDLE) && tx_valid;
  assign hdr_byte = tx_hdr_sel ? HDR_C : HDR_A;
  assign bit_pos  = {byte_idx_reg, bit_cnt_reg};  // byte*8 + bit

  // Next-state decode and Moore outputs.
  always_comb begin
    state_next  = state_reg;
    tx_ready    = 1'b0;
    data_ena    = 1'b0;
    serial_data = 1'b0;
    case (state_reg)
      IDLE: begin
        tx_ready = 1'b1;
        if (tx_valid) state_next = SHIFT;
      end
      SHIFT: begin
        data_ena    = 1'b1;
        serial_data = pkt_reg[bit_pos];
        if (bit_cnt_reg == 3'd7)
          state_next = (byte_idx_reg == 3'd4) ? PKT_WAIT : GAP;
      end
      GAP: begin
        if (gap_cnt_reg == GAP_LAST) state_next = SHIFT;
      end
      PKT_WAIT: begin
        if (gap_cnt_reg == WAIT_LAST) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign subst   = subst_reg;
  assign pkt_cnt = pkt_cnt_reg;

  // State register plus packet capture, bit/byte/gap counters and packet counter.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_reg    <= IDLE;
      pkt_reg      <= '0;
      bit_cnt_reg  <= '0;
      byte_idx_reg <= '0;
      gap_cnt_reg  <= '0;
      subst_reg    <= 1'b0;
      pkt_cnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      subst_reg <= accept && (|byte_hit);
      case (state_reg)
        IDLE: begin
          if (accept) begin
            pkt_reg      <= {clean_byte[3], clean_byte[2], clean_byte[1],
                             clean_byte[0], hdr_byte};
            bit_cnt_reg  <= '0;
            byte_idx_reg <= '0;
            gap_cnt_reg  <= '0;
          end
        end
        SHIFT: begin
          bit_cnt_reg <= bit_cnt_reg + 3'd1;
          gap_cnt_reg <= '0;
          if (bit_cnt_reg == 3'd7) byte_idx_reg <= byte_idx_reg + 3'd1;
        end
        GAP: begin
          gap_cnt_reg <= gap_cnt_reg + 4'd1;
        end
        PKT_WAIT: begin
          gap_cnt_reg <= gap_cnt_reg + 4'd1;
          if (gap_cnt_reg == WAIT_LAST) pkt_cnt_reg <= pkt_cnt_reg + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tas_serial_tx.sv
// Testbench for tas_serial_tx: directed vector table, randomized packets
// against a stream-level model, back-to-back, mid-packet reset and counter wrap.
module tb_tas_serial_tx;

  localparam int G = 2;
  localparam int P = 4;
  localparam int L = 40 + 4*G + P;  // busy cycles per packet

  logic        clk_50;
  logic        reset;
  logic        tx_valid;
  logic [31:0] tx_temp;
  logic        tx_hdr_sel;
  logic        tx_ready;
  logic        serial_data;
  logic        data_ena;
  logic        subst;
  logic [15:0] pkt_cnt;

  int          checks;
  int          errors;
  logic [15:0] exp_cnt;
  logic [39:0] last_bits;
  int          pkt_no;

  tas_serial_tx #(.GAP_CYCLES(G), .PKT_GAP(P)) dut (
    .clk_50(clk_50), .reset(reset), .tx_valid(tx_valid), .tx_temp(tx_temp),
    .tx_hdr_sel(tx_hdr_sel), .tx_ready(tx_ready), .serial_data(serial_data),
    .data_ena(data_ena), .subst(subst), .pkt_cnt(pkt_cnt)
  );

  initial clk_50 = 1'b0;
  always #5 clk_50 = ~clk_50;

  typedef struct {
    logic [31:0] temp;
    logic        hdr;
    logic [39:0] bytes;  // {byte3..byte0, header}, header sent first
    logic        sub;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: the wire image of a packet, from the substitution rules.
  function automatic logic [7:0] fix_byte(input logic [7:0] b);
    if (b == 8'hA5) return 8'hA4;
    if (b == 8'hC3) return 8'hC2;
    return b;
  endfunction

  function automatic logic [39:0] model_bytes(input logic [31:0] t, input logic h);
    logic [39:0] r;
    r[7:0] = h ? 8'hC3 : 8'hA5;
    for (int i = 0; i < 4; i++) r[8*(i+1) +: 8] = fix_byte(t[8*i +: 8]);
    return r;
  endfunction

  function automatic logic model_sub(input logic [31:0] t);
    logic s;
    s = 1'b0;
    for (int i = 0; i < 4; i++) if (fix_byte(t[8*i +: 8]) != t[8*i +: 8]) s = 1'b1;
    return s;
  endfunction

  // Model: data_ena is high for 8 cycles per byte, bytes start every 8+G cycles.
  function automatic logic [127:0] exp_ena();
    logic [127:0] e;
    e = '0;
    for (int j = 0; j < 5; j++)
      for (int b = 0; b < 8; b++) e[j*(8+G) + b] = 1'b1;
    return e;
  endfunction

  function automatic logic [7:0] rnd_byte();
    case ($urandom_range(0, 3))
      0:       return 8'hA5;
      1:       return 8'hC3;
      default: return 8'($urandom);
    endcase
  endfunction

  // Offer one packet, capture L cycles of output, then check the whole packet.
  task automatic run_pkt(input logic [31:0] temp, input logic hdr,
                         input logic [39:0] exp_bytes, input logic exp_sub,
                         input string name);
    logic [127:0] o_ena, o_sub;
    logic [39:0]  o_bits;
    int           nb, ready_hits, stray;
    o_ena = '0; o_sub = '0; o_bits = '0;
    nb = 0; ready_hits = 0; stray = 0;
    @(negedge clk_50);
    chk({name, "_ready_before"}, 128'(tx_ready), 128'(1'b1));
    tx_valid = 1'b1; tx_temp = temp; tx_hdr_sel = hdr;
    @(posedge clk_50); #1;
    tx_valid = 1'b0; tx_temp = $urandom; tx_hdr_sel = 1'($urandom_range(0, 1));
    for (int k = 0; k < L; k++) begin
      @(negedge clk_50);
      o_ena[k] = data_ena;
      o_sub[k] = subst;
      if (data_ena) begin
        if (nb < 40) o_bits[nb] = serial_data;
        nb++;
      end else if (serial_data) stray++;
      if (tx_ready) ready_hits++;
      if (k % 7 == 3) tx_temp = $urandom;
    end
    @(negedge clk_50);
    exp_cnt = exp_cnt + 16'd1;
    chk({name, "_ready_after"}, 128'(tx_ready), 128'(1'b1));
    chk({name, "_pkt_cnt"}, 128'(pkt_cnt), 128'(exp_cnt));
    chk({name, "_ena"}, o_ena, exp_ena());
    chk({name, "_bytes"}, 128'(o_bits), 128'(exp_bytes));
    chk({name, "_subst"}, o_sub, 128'(exp_sub));
    chk({name, "_busy"}, 128'(ready_hits), 128'(0));
    chk({name, "_idle_data"}, 128'(stray), 128'(0));
    last_bits = o_bits;
    pkt_no++;
    $display("pkt %0d %s temp=%08h hdr=%0d sent=%010h subst=%0d cnt=%0d",
             pkt_no, name, temp, hdr, o_bits, |o_sub, pkt_cnt);
  endtask

  initial begin
    bit ena_arr [0:511];
    int span, mism, runs5, runs_bad, zrun, seen_one, ena_seen;
    logic [31:0] t;
    logic        h;
    int          avg;

    checks = 0; errors = 0; exp_cnt = '0; pkt_no = 0; last_bits = '0;
    tbl[0] = '{32'h1B1A1918, 1'b0, 40'h1B1A1918A5, 1'b0};
    tbl[1] = '{32'h00C3A520, 1'b0, 40'h00C2A420A5, 1'b1};
    tbl[2] = '{32'h281E140A, 1'b1, 40'h281E140AC3, 1'b0};
    tbl[3] = '{32'hC3C3A5A5, 1'b1, 40'hC2C2A4A4C3, 1'b1};
    tbl[4] = '{32'hA6C4A4C2, 1'b0, 40'hA6C4A4C2A5, 1'b0};

    // Reset state, with tx_valid high during reset (must be ignored)
    reset = 1'b1; tx_valid = 1'b1; tx_temp = 32'h12345678; tx_hdr_sel = 1'b0;
    repeat (3) @(negedge clk_50);
    chk("rst_ready", 128'(tx_ready), 128'(1'b1));
    chk("rst_ena", 128'(data_ena), 128'(1'b0));
    chk("rst_data", 128'(serial_data), 128'(1'b0));
    chk("rst_subst", 128'(subst), 128'(1'b0));
    chk("rst_cnt", 128'(pkt_cnt), 128'(16'd0));
    reset = 1'b0; tx_valid = 1'b0;
    @(negedge clk_50);
    chk("rst_release_ready", 128'(tx_ready), 128'(1'b1));
    chk("rst_release_ena", 128'(data_ena), 128'(1'b0));

    // Directed vector table
    for (int i = 0; i < 5; i++) begin
      run_pkt(tbl[i].temp, tbl[i].hdr, tbl[i].bytes, tbl[i].sub, $sformatf("vec%0d", i));
      if (i == 2) begin
        avg = (int'(last_bits[15:8]) + int'(last_bits[23:16]) +
               int'(last_bits[31:24]) + int'(last_bits[39:32])) / 4;
        chk("loopback_avg", 128'(avg), 128'(25));
      end
    end

    // Randomized packets against the model
    for (int r = 0; r < 10; r++) begin
      t = {rnd_byte(), rnd_byte(), rnd_byte(), rnd_byte()};
      h = 1'($urandom_range(0, 1));
      run_pkt(t, h, model_bytes(t, h), model_sub(t), $sformatf("rnd%0d", r));
    end

    // Back-to-back: tx_valid held for three packets
    span = 3 * (L + 1);
    @(negedge clk_50);
    tx_valid = 1'b1; tx_temp = 32'h44332211; tx_hdr_sel = 1'b0;
    @(posedge clk_50); #1;
    for (int k = 0; k < span; k++) begin
      @(negedge clk_50);
      ena_arr[k] = data_ena;
      if (k == 2 * (L + 1)) tx_valid = 1'b0;
    end
    exp_cnt = exp_cnt + 16'd3;
    chk("b2b_ready_after", 128'(tx_ready), 128'(1'b1));
    chk("b2b_pkt_cnt", 128'(pkt_cnt), 128'(exp_cnt));
    mism = 0;
    for (int p = 0; p < 3; p++)
      for (int k = 0; k < L + 1; k++)
        if (ena_arr[p*(L+1) + k] != bit'(exp_ena() >> k)) mism++;
    chk("b2b_ena_pattern", 128'(mism), 128'(0));
    runs5 = 0; runs_bad = 0; zrun = 0; seen_one = 0;
    for (int k = 0; k < span; k++) begin
      if (ena_arr[k]) begin
        if (seen_one != 0 && zrun != 0) begin
          if (zrun == P + 1) runs5++;
          else if (zrun != G) runs_bad++;
        end
        seen_one = 1; zrun = 0;
      end else zrun++;
    end
    chk("b2b_pkt_gaps", 128'(runs5), 128'(2));
    chk("b2b_other_gaps", 128'(runs_bad), 128'(0));
    ena_seen = 0;
    repeat (10) begin
      @(negedge clk_50);
      if (data_ena) ena_seen++;
    end
    chk("b2b_no_fourth", 128'(ena_seen), 128'(0));
    $display("b2b three packets cnt=%0d", pkt_cnt);

    // Reset at cycle 20 of a packet
    @(negedge clk_50);
    tx_valid = 1'b1; tx_temp = 32'h55667788; tx_hdr_sel = 1'b1;
    @(posedge clk_50); #1;
    tx_valid = 1'b0;
    for (int k = 0; k < 20; k++) @(negedge clk_50);
    reset = 1'b1; tx_valid = 1'b1;
    ena_seen = 0;
    repeat (3) begin
      @(negedge clk_50);
      if (data_ena) ena_seen++;
    end
    chk("abort_cnt", 128'(pkt_cnt), 128'(16'd0));
    reset = 1'b0; tx_valid = 1'b0;
    exp_cnt = '0;
    @(negedge clk_50);
    chk("abort_ready", 128'(tx_ready), 128'(1'b1));
    for (int k = 0; k < L; k++) begin
      @(negedge clk_50);
      if (data_ena) ena_seen++;
    end
    chk("abort_no_ena", 128'(ena_seen), 128'(0));
    chk("abort_cnt_after", 128'(pkt_cnt), 128'(16'd0));
    $display("abort reset mid-packet cnt=%0d", pkt_cnt);

    // Counter wrap
    @(negedge clk_50);
    force dut.pkt_cnt_reg = 16'hFFFF;
    @(negedge clk_50);
    release dut.pkt_cnt_reg;
    exp_cnt = 16'hFFFF;
    chk("wrap_preload", 128'(pkt_cnt), 128'(16'hFFFF));
    run_pkt(32'h01020304, 1'b0, 40'h01020304A5, 1'b0, "wrap");
    chk("wrap_zero", 128'(pkt_cnt), 128'(16'd0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tas_serial_tx.md
TAS_SERIAL_TX -- requirements
Module: tas_serial_tx

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 2, meaning data_ena-low cycles between bytes within a packet (legal range 1..15).
REQ-002 SHALL have parameter PKT_GAP, default 4, meaning idle cycles after the last byte before tx_ready reasserts (legal range 1..15).
REQ-003 SHALL have one clock and a synchronous, active-high reset; all state updates on the rising edge of clk_50.
REQ-004 SHALL have port clk_50 input 1: 50 MHz clock.
REQ-005 SHALL have port reset input 1: synchronous reset, active high.
REQ-006 SHALL have port tx_valid input 1: a packet is offered on tx_temp/tx_hdr_sel.
REQ-007 SHALL have port tx_temp input 32: four temperature bytes; byte0 in [7:0], byte3 in [31:24].
REQ-008 SHALL have port tx_hdr_sel input 1: header select, 0 selects 8'hA5 and 1 selects 8'hC3.
REQ-009 SHALL have port tx_ready output 1: block can accept a packet.
REQ-010 SHALL have port serial_data output 1: serial bit stream.
REQ-011 SHALL have port data_ena output 1: serial bit qualifier.
REQ-012 SHALL have port subst output 1: one-cycle pulse indicating that a temperature byte was altered at acceptance.
REQ-013 SHALL have port pkt_cnt output 16: count of completed packets.

Function
REQ-014 SHALL implement the states IDLE, SHIFT, GAP and PKT_WAIT; tx_ready = (state == IDLE).
REQ-015 SHALL accept a packet at a clock edge where tx_valid && tx_ready; tx_valid is ignored at all other times.
REQ-016 On acceptance SHALL register the header (A5 or C3) plus the four bytes, then go IDLE->SHIFT with byte index 0 as the header.
REQ-017 On acceptance SHALL replace any temperature byte equal to 8'hA5 with 8'hA4 and any byte equal to 8'hC3 with 8'hC2, and pulse subst high during the first SHIFT cycle if at least one byte was replaced.
REQ-018 SHALL send the packet as: header, byte0, byte1, byte2, byte3.
REQ-019 SHALL send each byte LSB first, one bit per clock, over 8 consecutive cycles with data_ena=1.
REQ-020 SHALL drive data_ena=1 first in the cycle immediately after acceptance (latency 1).
REQ-021 In SHIFT, serial_data SHALL equal bit[bit_cnt] of the current byte; bit_cnt counts 0..7 (3 bits).
REQ-022 After bit 7 of bytes 0..3 of the packet (header through byte2) SHALL go to GAP for exactly GAP_CYCLES cycles, then return to SHIFT with the next byte.
REQ-023 After bit 7 of byte3 SHALL go to PKT_WAIT for exactly PKT_GAP cycles, then go to IDLE.
REQ-024 SHALL hold data_ena=0 and serial_data=0 in IDLE, GAP and PKT_WAIT.
REQ-025 SHALL take 40 + 4*GAP_CYCLES + PKT_GAP cycles from acceptance edge to tx_ready=1; with defaults this is 52 cycles.
REQ-026 SHALL increment pkt_cnt on the PKT_WAIT->IDLE transition; pkt_cnt wraps 16'hFFFF -> 0.
REQ-027 tx_temp and tx_hdr_sel changes after acceptance SHALL NOT affect the packet in flight.
REQ-028 tx_valid held high continuously SHALL produce back-to-back packets separated by PKT_GAP idle cycles plus one IDLE cycle.

Reset
REQ-029 While reset=1 the block SHALL force state=IDLE, data_ena=0, serial_data=0, subst=0, pkt_cnt=0, and clear bit/byte/gap counters.
REQ-030 tx_ready SHALL be 1 in the first cycle after reset deasserts; tx_valid sampled while reset=1 SHALL be ignored.
REQ-031 Reset asserted mid-packet SHALL abort the packet at that edge, with no further data_ena pulses, and SHALL NOT increment pkt_cnt.

Verification
REQ-032 Accept tx_temp=32'h1B1A1918 with hdr_sel=0 -> serial bytes A5,18,19,1A,1B are sent LSB first, 8 data_ena cycles each, with 2-cycle gaps; tx_ready returns after 52 cycles; pkt_cnt=1.
REQ-033 Accept tx_temp=32'h00C3A520 -> bytes 20,A4,C2,00 are sent, and subst pulses for exactly 1 cycle.
REQ-034 Hold tx_valid=1 for 3 packets -> 3 packets are sent; each inter-packet low gap on data_ena is 5 cycles; pkt_cnt=3.
REQ-035 Assert reset at cycle 20 of a packet -> data_ena=0 from the next cycle onward; pkt_cnt=0; tx_ready=1 in the cycle after reset releases.
REQ-036 Loopback into the existing averaging receiver with bytes 10,20,30,40 (decimal) -> the receiver writes average 25 (8'h19) to RAM.
REQ-037 Preload pkt_cnt=16'hFFFF via a force, then send 1 packet -> pkt_cnt=0.
